// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and helpers for the 4-bit CPU run/halt/step controller.
package lib_cpu;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    BREAK = 2'd3
  } RUN_STATE;

  // Prescaler counter width; DIV = 1 still needs a 1-bit register.
  function automatic int unsigned presc_width(input int unsigned div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

  function automatic logic state_halted(input RUN_STATE s);
    return (s == HALT) || (s == BREAK);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_btn_edge.sv
// Two-flop synchronizer plus rising-edge detector for raw board buttons.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step controller producing the one-cycle CPU register update enable.
module cpu_run_ctrl
  import lib_cpu::*;
#(
  parameter int unsigned DIV = 2_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_sw,
  input  logic       step_btn,
  input  logic       bp_en,
  input  logic [3:0] bp_addr,
  input  logic [3:0] ip,
  output logic       cpu_en,
  output logic [1:0] state,
  output logic       halted,
  output logic [7:0] instr_count
);

  localparam int unsigned PW = presc_width(DIV);
  localparam logic [PW-1:0] PrescLast = PW'(DIV - 1);

  RUN_STATE      state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          cpu_en_q, cpu_en_d;
  logic [7:0]    count_q;
  logic          step_edge;
  logic          tick;
  logic          bp_hit;

  btn_edge u_step_edge (
    .clk   (clk),
    .reset (reset),
    .in    (step_btn),
    .rise  (step_edge)
  );

  assign tick   = (state_q == RUN) && (presc_q == PrescLast);
  assign bp_hit = bp_en && (ip == bp_addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HALT;
    end else begin
      state_q <= state_d;
    end
  end

  // Run request beats a simultaneous step; BREAK only leaves via HALT or STEP.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HALT: begin
        if (run_sw)         state_d = RUN;
        else if (step_edge) state_d = STEP;
      end
      RUN: begin
        if (!run_sw)            state_d = HALT;
        else if (tick && bp_hit) state_d = BREAK;
      end
      STEP: state_d = HALT;
      BREAK: begin
        if (!run_sw)        state_d = HALT;
        else if (step_edge) state_d = STEP;
      end
      default: state_d = HALT;
    endcase
  end

  always_comb begin
    cpu_en_d = (state_q == STEP) || (tick && run_sw && !bp_hit);
    halted   = state_halted(state_q);
  end

  // Prescaler only advances while staying in RUN; any other path leaves it at 0.
  always_comb begin
    presc_d = '0;
    if (state_q == RUN && run_sw && !tick) begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q  <= '0;
      cpu_en_q <= 1'b0;
      count_q  <= 8'd0;
    end else begin
      presc_q  <= presc_d;
      cpu_en_q <= cpu_en_d;
      if (cpu_en_q) begin
        count_q <= count_q + 8'd1;
      end
    end
  end

  assign cpu_en      = cpu_en_q;
  assign state       = state_q;
  assign instr_count = count_q;

endmodule
